// File: rtl/pipe_stage_buf.sv
// Pipeline-stage boundary register carrying a data word and a control word over valid/ready.
// Optional 2-entry skid buffer (SKID=1) registers in_ready; bubbles always present a zero control word.
module pipe_stage_buf #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned CTRL_W      = 8,
   parameter int unsigned SKID        = 1,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic [CTRL_W-1:0]      in_ctrl,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   state_e                 state_q,     state_d;
   logic [DATA_W-1:0]      main_data_q, main_data_d;
   logic [CTRL_W-1:0]      main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0]      skid_data_q, skid_data_d;
   logic [CTRL_W-1:0]      skid_ctrl_q, skid_ctrl_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic acc;
   logic pop;

   // Handshake and output decode, all from the state register except the SKID=0 ready path.
   always_comb begin
      out_valid = (state_q != ST_EMPTY);
      if (SKID != 0) begin
         in_ready = (state_q != ST_TWO);
      end else begin
         in_ready = !out_valid || out_ready;
      end
      acc       = in_valid && in_ready;
      pop       = out_valid && out_ready;
      out_data  = main_data_q;
      out_ctrl  = out_valid ? main_ctrl_q : '0;
      unique case (state_q)
         ST_ONE:  occupancy = 2'd1;
         ST_TWO:  occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;

      // Flush wins outright: the offered input is not captured, so out_data keeps its old value.
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  state_d     = ST_ONE;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end
            end
            ST_ONE: begin
               if (acc && pop) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end else if (acc && (SKID != 0)) begin
                  state_d     = ST_TWO;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  state_d     = ST_ONE;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Stall counter saturates and is independent of flush.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   // NOTE: datapath registers are reset as well, so out_data reads 0 after reset instead of X.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives a SKID=1 (4-bit stall counter) and a SKID=0 (16-bit stall counter) stage with shared
// stimulus and compares both against queue-based reference models.
module tb_pipe_stage_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_data;
   logic [7:0]  in_ctrl;

   logic        s_in_ready, s_out_valid;
   logic [31:0] s_out_data;
   logic [7:0]  s_out_ctrl;
   logic [1:0]  s_occupancy;
   logic [3:0]  s_stall_cnt;

   logic        n_in_ready, n_out_valid;
   logic [31:0] n_out_data;
   logic [7:0]  n_out_ctrl;
   logic [1:0]  n_occupancy;
   logic [15:0] n_stall_cnt;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(1), .STALL_CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
      .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
   );

   pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(0), .STALL_CNT_W(16)) dut_n (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data), .out_ctrl(n_out_ctrl),
      .occupancy(n_occupancy), .stall_cnt(n_stall_cnt)
   );

   typedef struct {
      logic [31:0] d;
      logic [7:0]  c;
   } ent_t;

   ent_t        qs[$];
   ent_t        qn[$];
   int unsigned sc_s, sc_n;
   logic [31:0] shown_s, shown_n;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      qs.delete();
      qn.delete();
      sc_s    = 0;
      sc_n    = 0;
      shown_s = '0;
      shown_n = '0;
   endtask

   // One clock edge of both stages: FIFO of capacity 2 / 1, pop before push, flush empties.
   task automatic model_edge();
      bit rdy_s, rdy_n;
      rdy_s = (qs.size() < 2);
      rdy_n = (qn.size() == 0) || out_ready;
      if (qs.size() > 0 && !out_ready && sc_s < 15)    sc_s++;
      if (qn.size() > 0 && !out_ready && sc_n < 65535) sc_n++;
      if (flush) begin
         qs.delete();
         qn.delete();
      end else begin
         if (qs.size() > 0 && out_ready) void'(qs.pop_front());
         if (qn.size() > 0 && out_ready) void'(qn.pop_front());
         if (in_valid && rdy_s) qs.push_back('{in_data, in_ctrl});
         if (in_valid && rdy_n) qn.push_back('{in_data, in_ctrl});
      end
      if (qs.size() > 0) shown_s = qs[0].d;
      if (qn.size() > 0) shown_n = qn[0].d;
   endtask

   task automatic chk_all();
      logic [7:0] ec_s, ec_n;
      ec_s = (qs.size() > 0) ? qs[0].c : 8'h00;
      ec_n = (qn.size() > 0) ? qn[0].c : 8'h00;
      check("s_in_ready",  64'(s_in_ready),  64'(qs.size() < 2));
      check("s_out_valid", 64'(s_out_valid), 64'(qs.size() > 0));
      check("s_out_data",  64'(s_out_data),  64'(shown_s));
      check("s_out_ctrl",  64'(s_out_ctrl),  64'(ec_s));
      check("s_occupancy", 64'(s_occupancy), 64'(qs.size()));
      check("s_stall_cnt", 64'(s_stall_cnt), 64'(sc_s));
      check("n_in_ready",  64'(n_in_ready),  64'((qn.size() == 0) || out_ready));
      check("n_out_valid", 64'(n_out_valid), 64'(qn.size() > 0));
      check("n_out_data",  64'(n_out_data),  64'(shown_n));
      check("n_out_ctrl",  64'(n_out_ctrl),  64'(ec_n));
      check("n_occupancy", 64'(n_occupancy), 64'(qn.size()));
      check("n_stall_cnt", 64'(n_stall_cnt), 64'(sc_n));
   endtask

   // Called at a negedge with inputs already set: check, clock once, return at the next negedge.
   task automatic step();
      #1;
      chk_all();
      @(posedge clk);
      if (rst) model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c,
                        input logic rdy, input logic fl);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = rdy;
      flush     = fl;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      model_reset();
      step();
      step();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      model_reset();
      @(negedge clk);
      apply_reset();

      // Streaming: one-cycle latency, ready stays high.
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i), 8'(8'h10 + i), 1'b1, 1'b0);
         step();
         check("t1_ready", 64'(s_in_ready), 64'd1);
      end
      check("t1_last_data", 64'(s_out_data), 64'h8);
      check("t1_occ", 64'(s_occupancy), 64'd1);

      // Bubbles after the stream drains.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'hDEAD_0000 + 32'(i), 8'hFF, 1'b1, 1'b0);
         step();
      end
      check("t4_valid", 64'(s_out_valid), 64'd0);
      check("t4_ctrl",  64'(s_out_ctrl),  64'h00);
      check("t4_occ",   64'(n_occupancy), 64'd0);

      // Skid: 0xA held, 0xB pushed under backpressure, then drained in order.
      drive(1'b1, 32'hA, 8'hA5, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hB, 8'hB5, 1'b0, 1'b0);
      step();
      check("t2_ready0", 64'(s_in_ready),  64'd0);
      check("t2_occ2",   64'(s_occupancy), 64'd2);
      check("t2_headA",  64'(s_out_data),  64'hA);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      check("t2_headB",  64'(s_out_data),  64'hB);
      check("t2_ctrlB",  64'(s_out_ctrl),  64'hB5);
      step();

      // Flush in TWO with a live input offered.
      drive(1'b1, 32'h1, 8'h11, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h2, 8'h22, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hC, 8'hCC, 1'b0, 1'b1);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("t3_valid", 64'(s_out_valid), 64'd0);
      check("t3_ctrl",  64'(s_out_ctrl),  64'h00);
      check("t3_occ",   64'(s_occupancy), 64'd0);
      check("t3_ready", 64'(s_in_ready),  64'd1);
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step();

      // Stall saturation from a clean counter.
      apply_reset();
      drive(1'b1, 32'h1234_5678, 8'h3C, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step();
      check("t5_sat_s",   64'(s_stall_cnt), 64'd15);
      check("t5_cnt_n",   64'(n_stall_cnt), 64'd20);
      check("t5_stable",  64'(s_out_data),  64'h1234_5678);

      // Asynchronous reset in the middle of the stall.
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk_all();
      check("t6_valid", 64'(s_out_valid), 64'd0);
      check("t6_data",  64'(n_out_data),  64'h0);
      @(negedge clk);
      step();
      rst = 1'b1;

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), $urandom, 8'($urandom_range(1, 255)),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
         step();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
